// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op codes, FSM state codes and width default for the
// HI/LO multiply/divide engine. Op codes follow the EX-stage ALU style.
package muldiv_unit_pkg;
  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_OP_MULT  = 3'b000;
  localparam logic [2:0] MD_OP_MULTU = 3'b001;
  localparam logic [2:0] MD_OP_MADD  = 3'b010;
  localparam logic [2:0] MD_OP_MADDU = 3'b011;
  localparam logic [2:0] MD_OP_MSUB  = 3'b100;
  localparam logic [2:0] MD_OP_MSUBU = 3'b101;
  localparam logic [2:0] MD_OP_DIV   = 3'b110;
  localparam logic [2:0] MD_OP_DIVU  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Even op codes are the signed variants.
  function automatic logic md_is_signed(logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_is_div(logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage <-> muldiv_unit handshake and operand/result bus.
//   master: EX side (drives start/op/operands/forwarded HI,LO/cancel)
//   slave : the unit (drives stallreq/busy/done/results/whilo)
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(parameter int WIDTH = MD_WIDTH) ();
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic             cancel_i;
  logic             stallreq_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             whilo_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, hi_i, lo_i, cancel_i,
    input  stallreq_o, busy_o, done_o, hi_o, lo_o, whilo_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, hi_i, lo_i, cancel_i,
    output stallreq_o, busy_o, done_o, hi_o, lo_o, whilo_o
  );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// muldiv_unit_div_iter: restoring radix-2 divider datapath, one quotient bit
// per step, MSB first, on operand magnitudes.
//   load_i   : capture operands (signedness from signed_i)
//   step_i   : perform one iteration
//   last_o   : the current step is the final (WIDTH-th) iteration
//   quot_o / rem_o : signed-fixed result of the *current* step's next state,
//                    so the parent can register it on the final step edge.
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
#(parameter int WIDTH = MD_WIDTH) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvd_q, diff;
  logic [WIDTH:0]   rem_sh;
  logic             qneg_q, rneg_q, zero_q, ge;
  logic             a_neg, b_neg;

  assign a_neg = signed_i & opa_i[WIDTH-1];
  assign b_neg = signed_i & opb_i[WIDTH-1];

  // Shift the next dividend bit into the partial remainder and try to
  // subtract. When it fits, the true difference is below the divisor, so
  // the low WIDTH bits of the subtraction are exact.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    diff   = rem_sh[WIDTH-1:0] - dvs_q;
    rem_d  = ge ? diff : rem_sh[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], ge};
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  // Divide by zero reports all-ones quotient and the untouched dividend.
  assign quot_o = zero_q ? '1    : (qneg_q ? -quo_d : quo_d);
  assign rem_o  = zero_q ? dvd_q : (rneg_q ? -rem_d : rem_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= a_neg ? -opa_i : opa_i;
      dvs_q  <= b_neg ? -opb_i : opb_i;
      dvd_q  <= opa_i;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      zero_q <= (opb_i == '0);
    end else if (step_i) begin
      cnt_q <= cnt_q + CW'(1);
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO engine (MULT/MADD/MSUB/DIV, signed+unsigned).
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_unit_if.slave -- start/op/operands/forwarded HI,LO/cancel
//              in; stallreq/busy/done/hi/lo/whilo out.
// Latency start->done: multiply 2, divide WIDTH+1, skipped divide-by-zero 1.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH         = MD_WIDTH,
  parameter int DIV_SKIP_ZERO = 1
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q, hacc_q, lacc_q;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic             accept, skip_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    prod_u, prod, acc, mul_res;
  logic             div_last;
  logic [WIDTH-1:0] div_quot, div_rem;

  assign accept    = (state_q == ST_IDLE) && bus.start_i && !bus.cancel_i;
  assign skip_zero = (DIV_SKIP_ZERO != 0) && (bus.opb_i == '0);

  // Multiply on magnitudes, then restore the sign.
  assign a_neg   = md_is_signed(op_q) & opa_q[WIDTH-1];
  assign b_neg   = md_is_signed(op_q) & opb_q[WIDTH-1];
  assign mag_a   = a_neg ? -opa_q : opa_q;
  assign mag_b   = b_neg ? -opb_q : opb_q;
  assign prod_u  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign prod    = (a_neg ^ b_neg) ? -prod_u : prod_u;
  assign acc     = {hacc_q, lacc_q};
  assign mul_res = (op_q[2:1] == 2'b01) ? acc + prod :
                   (op_q[2:1] == 2'b10) ? acc - prod : prod;

  muldiv_unit_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept && md_is_div(bus.op_i)),
    .step_i   ((state_q == ST_DIV) && !bus.cancel_i),
    .signed_i (md_is_signed(bus.op_i)),
    .opa_i    (bus.opa_i),
    .opb_i    (bus.opb_i),
    .last_o   (div_last),
    .quot_o   (div_quot),
    .rem_o    (div_rem)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.cancel_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start_i) begin
          if (!md_is_div(bus.op_i)) begin
            state_d = ST_MUL;
          end else if (skip_zero) begin
            state_d = ST_DONE;
            hi_d    = bus.opa_i;
            lo_d    = '1;
          end else begin
            state_d = ST_DIV;
          end
        end
        ST_MUL: begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_DONE;
        end
        ST_DIV: if (div_last) begin
          hi_d    = div_rem;
          lo_d    = div_quot;
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;  // DONE: start here belongs to the finishing instr
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hacc_q  <= '0;
      lacc_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (accept) begin
        op_q   <= bus.op_i;
        opa_q  <= bus.opa_i;
        opb_q  <= bus.opb_i;
        hacc_q <= bus.hi_i;
        lacc_q <= bus.lo_i;
      end
    end
  end

  assign bus.stallreq_o = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.busy_o     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done_o     = (state_q == ST_DONE);
  assign bus.whilo_o    = (state_q == ST_DONE);
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (32-bit skip, 32-bit no-skip,
// 16-bit). Expected results go to a per-instance queue when an op is issued
// and are popped by a monitor whenever done_o pulses.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.WIDTH(32)) b0 ();
  muldiv_unit_if #(.WIDTH(32)) b1 ();
  muldiv_unit_if #(.WIDTH(16)) b2 ();

  muldiv_unit #(.WIDTH(32), .DIV_SKIP_ZERO(1)) u_dut    (.clk(clk), .rst(rst), .bus(b0));
  muldiv_unit #(.WIDTH(32), .DIV_SKIP_ZERO(0)) u_dut_ns (.clk(clk), .rst(rst), .bus(b1));
  muldiv_unit #(.WIDTH(16), .DIV_SKIP_ZERO(1)) u_dut16  (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(string tag, logic [67:0] obs, logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int sel, logic st, logic [2:0] op, logic [31:0] a, b, h, l, logic cn);
    case (sel)
      0: begin b0.start_i = st; b0.op_i = op; b0.opa_i = a; b0.opb_i = b;
               b0.hi_i = h; b0.lo_i = l; b0.cancel_i = cn; end
      1: begin b1.start_i = st; b1.op_i = op; b1.opa_i = a; b1.opb_i = b;
               b1.hi_i = h; b1.lo_i = l; b1.cancel_i = cn; end
      default: begin b2.start_i = st; b2.op_i = op; b2.opa_i = a[15:0]; b2.opb_i = b[15:0];
               b2.hi_i = h[15:0]; b2.lo_i = l[15:0]; b2.cancel_i = cn; end
    endcase
  endtask

  function automatic logic stall_of(int sel);
    return (sel == 0) ? b0.stallreq_o : (sel == 1) ? b1.stallreq_o : b2.stallreq_o;
  endfunction

  function automatic logic done_of(int sel);
    return (sel == 0) ? b0.done_o : (sel == 1) ? b1.done_o : b2.done_o;
  endfunction

  // {stallreq, busy, done, whilo, hi, lo} zero-extended to 68 bits
  function automatic logic [67:0] outs_of(int sel);
    case (sel)
      0: return {b0.stallreq_o, b0.busy_o, b0.done_o, b0.whilo_o, b0.hi_o, b0.lo_o};
      1: return {b1.stallreq_o, b1.busy_o, b1.done_o, b1.whilo_o, b1.hi_o, b1.lo_o};
      default: return {b2.stallreq_o, b2.busy_o, b2.done_o, b2.whilo_o,
                       16'h0, b2.hi_o, 16'h0, b2.lo_o};
    endcase
  endfunction

  task automatic mon(int sel, logic [31:0] hi, logic [31:0] lo, logic wl);
    exp_t e;
    int   have = 0;
    case (sel)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    chk($sformatf("done_expected[%0d]", sel), 68'(have), 68'd1);
    if (have == 1) begin
      chk($sformatf("hi[%0d]", sel), 68'(hi), 68'(e.hi));
      chk($sformatf("lo[%0d]", sel), 68'(lo), 68'(e.lo));
      chk($sformatf("done_cycle[%0d]", sel), 68'(cyc), 68'(e.cyc));
      chk($sformatf("whilo[%0d]", sel), 68'(wl), 68'd1);
    end
  endtask

  always @(negedge clk) if (!rst && b0.done_o) mon(0, b0.hi_o, b0.lo_o, b0.whilo_o);
  always @(negedge clk) if (!rst && b1.done_o) mon(1, b1.hi_o, b1.lo_o, b1.whilo_o);
  always @(negedge clk) if (!rst && b2.done_o) mon(2, {16'h0, b2.hi_o}, {16'h0, b2.lo_o}, b2.whilo_o);

  // Issue one op, push its expectation, wait (bounded) for done_o.
  // Operands and forwarded HI/LO are scrambled after the start cycle.
  task automatic run(int sel, logic [2:0] op, logic [31:0] a, b, h, l,
                     logic [31:0] ehi, elo, int lat, int est, bit hold);
    exp_t e;
    int   stalls = 0;
    int   seen = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, op, a, b, h, l, 1'b0);
    e.hi = ehi; e.lo = elo; e.cyc = cyc + lat;
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (stall_of(sel)) stalls++;
      if (done_of(sel)) seen = 1;
      @(posedge clk); #1;
      drive(sel, hold && (seen == 0), $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0);
    end
    chk("done_seen", 68'(seen), 68'd1);
    if (est >= 0) chk("stall_cycles", 68'(stalls), 68'(est));
  endtask

  initial begin
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'b0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("reset_outs[%0d]", s), outs_of(s), 68'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Multiply family
    run(0, MD_OP_MULT,  32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 2, 2, 0);
    run(0, MD_OP_MADDU, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFF, 32'h1, 32'h5, 2, 2, 0);
    run(0, MD_OP_MSUB,  32'd2, 32'd3, 32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2, 0);
    run(0, MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h1, 2, -1, 0);
    run(0, MD_OP_MADD,  32'd3, 32'hFFFFFFFE, 32'd0, 32'd10, 32'd0, 32'd4, 2, -1, 0);
    run(0, MD_OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, -1, 0);

    // Divide family
    run(0, MD_OP_DIV,  32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33, 0);
    run(0, MD_OP_DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 33, -1, 0);
    run(0, MD_OP_DIV,  32'd100, 32'hFFFFFFF9, 0, 0, 32'd2, 32'hFFFFFFF2, 33, -1, 0);
    run(0, MD_OP_DIVU, 32'h1234, 32'd0, 0, 0, 32'h1234, 32'hFFFFFFFF, 1, 1, 0);
    run(0, MD_OP_DIV,  32'hFFFFFFFB, 32'd0, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, -1, 0);

    // start held through DONE: one pulse only (monitor flags any extra)
    run(0, MD_OP_MULTU, 32'd9, 32'd9, 0, 0, 32'd0, 32'd81, 2, 2, 1);
    repeat (5) @(posedge clk);
    chk("no_extra_done_q0", 68'(q0.size()), 68'd0);

    // Cancel at DIV iteration 10
    @(posedge clk); #1; drive(0, 1'b1, MD_OP_DIVU, 32'd1000, 32'd3, 0, 0, 1'b0);
    @(posedge clk); #1; drive(0, 1'b0, MD_OP_DIVU, 32'd0, 32'd0, 0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1; b0.cancel_i = 1'b1;
    @(negedge clk); chk("busy_before_cancel", 68'(b0.busy_o), 68'd1);
    @(posedge clk); #1; b0.cancel_i = 1'b0;
    @(negedge clk);
    chk("cancel_idle", 68'({b0.stallreq_o, b0.busy_o, b0.done_o}), 68'd0);
    repeat (40) @(posedge clk);
    // start together with cancel in IDLE is ignored
    #1; drive(0, 1'b1, MD_OP_MULTU, 32'd2, 32'd2, 0, 0, 1'b1);
    @(posedge clk); #1; drive(0, 1'b0, MD_OP_MULTU, 32'd0, 32'd0, 0, 0, 1'b0);
    @(negedge clk); chk("start_with_cancel_ignored", 68'(b0.busy_o), 68'd0);
    repeat (4) @(posedge clk);
    run(0, MD_OP_MULTU, 32'd5, 32'd6, 0, 0, 32'd0, 32'd30, 2, 2, 0);

    // Reset in the middle of a divide
    @(posedge clk); #1; drive(0, 1'b1, MD_OP_DIV, 32'd77, 32'd5, 0, 0, 1'b0);
    @(posedge clk); #1; drive(0, 1'b0, MD_OP_DIV, 32'd0, 32'd0, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("reset_mid_div", outs_of(0), 68'd0);
    repeat (40) @(posedge clk);
    chk("no_done_after_reset", 68'(q0.size()), 68'd0);

    // No-skip build: zero divisor iterates the full length
    run(1, MD_OP_DIVU, 32'h1234, 32'd0, 0, 0, 32'h1234, 32'hFFFFFFFF, 33, 33, 0);
    // 16-bit build
    run(2, MD_OP_DIV, 32'hFFFFFF9C, 32'd9, 0, 0, 32'hFFFF, 32'hFFF5, 17, 17, 0);
    run(2, MD_OP_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFF, 32'hFFFA, 2, -1, 0);

    repeat (3) @(posedge clk);
    chk("queues_drained", 68'(q0.size() + q1.size() + q2.size()), 68'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
